// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB stage: bus req/ack access, load alignment, register writeback
// Build macro MEM_UNALIGNED_ROTATE_EN: unaligned word loads return rdata rotated right (ARMv4 LDR).
module mem_wb_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_memctrl_vld,
   input  logic        i_memctrl_wr,
   input  logic        i_memctrl_sign,
   input  logic [1:0]  i_memctrl_size,
   input  logic [31:0] i_memctrl_addr,
   input  logic [31:0] i_memctrl_wdata,
   input  logic [31:0] i_wb_op,
   input  logic        i_wb_rd_src,
   input  logic        i_wb_rd_vld,
   input  logic [3:0]  i_wb_rd_code,
   output logic        o_stall,
   output logic        o_bus_req,
   output logic        o_bus_wr,
   output logic [31:0] o_bus_addr,
   output logic [3:0]  o_bus_be,
   output logic [31:0] o_bus_wdata,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rdata,
   output logic        o_rd_en_wb,
   output logic [3:0]  o_rd_code_wb,
   output logic [31:0] o_rd_reg_wb,
   output logic        o_data_abort
);

   localparam logic IDLE = 1'b0;
   localparam logic BUS  = 1'b1;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic          state;
   logic [CW-1:0] cnt;
   logic [1:0]    addr_lo;
   logic [1:0]    size_q;
   logic          sign_q;
   logic          rd_vld_q;
   logic [3:0]    rd_code_q;

   logic          accept;
   logic          timeout_hit;
   logic [3:0]    be_n;
   logic [31:0]   wdata_n;
   logic [7:0]    lane_byte;
   logic [15:0]   lane_half;
   logic [31:0]   load_data;

   assign o_stall     = (state == BUS) & ~i_bus_ack;
   assign o_bus_req   = (state == BUS);
   assign accept      = ~o_stall & i_memctrl_vld;
   assign timeout_hit = (TIMEOUT != 0) && (state == BUS) && !i_bus_ack && (cnt == CNT_LAST);

   always_comb begin
      be_n    = 4'b1111;
      wdata_n = i_memctrl_wdata;
      case (i_memctrl_size)
         2'b00: begin
            be_n    = 4'b0001 << i_memctrl_addr[1:0];
            wdata_n = {4{i_memctrl_wdata[7:0]}};
         end
         2'b01: begin
            be_n    = i_memctrl_addr[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{i_memctrl_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Extraction uses the latched access, so a request accepted on the ack edge cannot disturb it.
   assign lane_byte = 8'(i_bus_rdata >> {addr_lo, 3'b000});
   assign lane_half = addr_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

`ifdef MEM_UNALIGNED_ROTATE_EN
   logic [31:0] rotated;
   assign rotated = 32'({i_bus_rdata, i_bus_rdata} >> {addr_lo, 3'b000});
`endif

   always_comb begin
      load_data = i_bus_rdata;
      case (size_q)
         2'b00:   load_data = {{24{sign_q & lane_byte[7]}}, lane_byte};
         2'b01:   load_data = {{16{sign_q & lane_half[15]}}, lane_half};
`ifdef MEM_UNALIGNED_ROTATE_EN
         default: load_data = rotated;
`else
         default: load_data = i_bus_rdata;
`endif
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         cnt          <= '0;
         addr_lo      <= 2'b00;
         size_q       <= 2'b00;
         sign_q       <= 1'b0;
         rd_vld_q     <= 1'b0;
         rd_code_q    <= 4'd0;
         o_bus_wr     <= 1'b0;
         o_bus_addr   <= 32'd0;
         o_bus_be     <= 4'd0;
         o_bus_wdata  <= 32'd0;
         o_rd_en_wb   <= 1'b0;
         o_rd_code_wb <= 4'd0;
         o_rd_reg_wb  <= 32'd0;
         o_data_abort <= 1'b0;
      end else begin
         o_rd_en_wb   <= 1'b0;
         o_data_abort <= 1'b0;
         if (state == BUS) begin
            if (i_bus_ack) begin
               state <= IDLE;
               if (!o_bus_wr && rd_vld_q) begin
                  o_rd_en_wb   <= 1'b1;
                  o_rd_code_wb <= rd_code_q;
                  o_rd_reg_wb  <= load_data;
               end
            end else if (timeout_hit) begin
               state        <= IDLE;
               o_data_abort <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else if (!i_memctrl_vld && i_wb_rd_vld && !i_wb_rd_src) begin
            o_rd_en_wb   <= 1'b1;
            o_rd_code_wb <= i_wb_rd_code;
            o_rd_reg_wb  <= i_wb_op;
         end
         // Also fires on the ack edge, giving back-to-back accesses with no req gap.
         if (accept) begin
            state       <= BUS;
            cnt         <= '0;
            addr_lo     <= i_memctrl_addr[1:0];
            size_q      <= i_memctrl_size;
            sign_q      <= i_memctrl_sign;
            rd_vld_q    <= i_wb_rd_vld;
            rd_code_q   <= i_wb_rd_code;
            o_bus_wr    <= i_memctrl_wr;
            o_bus_addr  <= {i_memctrl_addr[31:2], 2'b00};
            o_bus_be    <= be_n;
            o_bus_wdata <= wdata_n;
         end
      end
   end

endmodule
